// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ writeback sources.
// Optional read-after-write forwarding ports are added when REGFILE_WR_FWD_EN is defined.
module regfile_write_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               write,
    output logic [AW-1:0]      writeaddress,
    output logic [DW-1:0]      writedata,
    output logic [1:0]         grant_id
`ifdef REGFILE_WR_FWD_EN
    ,
    input  logic [AW-1:0]      raddr1,
    input  logic [AW-1:0]      raddr2,
    input  logic [DW-1:0]      rdata1,
    input  logic [DW-1:0]      rdata2,
    output logic [DW-1:0]      fdata1,
    output logic [DW-1:0]      fdata2
`endif
);

    localparam int unsigned PW = 2;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [NREQ-1:0] grant_c;
    logic [PW-1:0]   gidx_c;
    logic [AW-1:0]   addr_c;
    logic [DW-1:0]   data_c;
    logic            accept_c;

    // Pick the first valid requester at or after ptr, wrapping to 0.
    always_comb begin
        grant_c  = '0;
        gidx_c   = '0;
        addr_c   = '0;
        data_c   = '0;
        accept_c = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!accept_c && req_valid[i] && (32'(i) >= 32'(ptr))) begin
                accept_c   = 1'b1;
                grant_c[i] = 1'b1;
                gidx_c     = PW'(i);
                addr_c     = req_addr[i*AW +: AW];
                data_c     = req_data[i*DW +: DW];
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!accept_c && req_valid[i] && (32'(i) < 32'(ptr))) begin
                accept_c   = 1'b1;
                grant_c[i] = 1'b1;
                gidx_c     = PW'(i);
                addr_c     = req_addr[i*AW +: AW];
                data_c     = req_data[i*DW +: DW];
            end
        end
        if (hold || !rst) begin
            grant_c  = '0;
            accept_c = 1'b0;
        end
    end

    assign req_ready = grant_c;

    always_comb begin
        ptr_nxt = ptr;
        if (accept_c) begin
            ptr_nxt = (32'(gidx_c) == NREQ - 1) ? '0 : gidx_c + PW'(1);
        end
    end

    // Output register stage; a write to r0 is consumed but never enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr          <= '0;
            write        <= 1'b0;
            writeaddress <= '0;
            writedata    <= '0;
            grant_id     <= '0;
        end else begin
            ptr   <= ptr_nxt;
            write <= accept_c && (addr_c != '0);
            if (accept_c) begin
                writeaddress <= addr_c;
                writedata    <= data_c;
                grant_id     <= gidx_c;
            end
        end
    end

`ifdef REGFILE_WR_FWD_EN
    // Bypass the write still in flight so readers never see stale data.
    assign fdata1 = (write && writeaddress == raddr1 && raddr1 != '0) ? writedata : rdata1;
    assign fdata2 = (write && writeaddress == raddr2 && raddr2 != '0) ? writedata : rdata2;
`endif

endmodule
